// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC engine arbiter and its helpers.
package cordic_pkg;

  localparam int ANGLE_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Bits needed to encode values 0..value-1 (at least 1).
  function automatic int cordic_clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cordic_arbiter_rr_picker.sv
// Combinational round-robin priority select: first set request bit found
// when searching ptr, ptr+1, ... wrapping modulo N.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] pos;

  // Walk the requests in rotated order and keep the first hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(ptr) + k) % N);
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one iterative CORDIC engine among NREQ requesters: round-robin
// accept, one start pulse, wait for done (with a watchdog), then a tagged
// response held until it is accepted.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = cordic_clog2(NREQ),
  parameter int ANGLE_W = ANGLE_W_DEF,
  parameter int TIMEOUT = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*ANGLE_W-1:0] req_angle,
  output logic [NREQ-1:0]         req_ready,
  output logic                    core_start,
  output logic [ANGLE_W-1:0]      core_angle,
  input  logic                    core_done,
  input  logic [ANGLE_W-1:0]      core_sine,
  input  logic [ANGLE_W-1:0]      core_cosine,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [ANGLE_W-1:0]      rsp_sine,
  output logic [ANGLE_W-1:0]      rsp_cosine,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int TW = cordic_clog2(TIMEOUT);

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [ANGLE_W-1:0] sine_q, sine_d;
  logic [ANGLE_W-1:0] cosine_q, cosine_d;
  logic               err_q, err_d;

  logic [NREQ-1:0]    pick_grant;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;
  logic [ANGLE_W-1:0] angle_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign angle_arr[gi] = req_angle[gi*ANGLE_W +: ANGLE_W];
  end

  rr_picker #(
    .N  (NREQ),
    .IW (IDW)
  ) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Accept pulse is only offered while idle; it follows req_valid directly.
  assign req_ready  = (state_q == ST_IDLE) ? pick_grant : '0;
  assign core_start = (state_q == ST_ISSUE);
  assign core_angle = angle_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_sine   = sine_q;
  assign rsp_cosine = cosine_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != ST_IDLE);

  // Next-state, watchdog and latch updates for the transaction sequencer.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    timer_d  = timer_q;
    angle_d  = angle_q;
    id_d     = id_q;
    sine_d   = sine_q;
    cosine_d = cosine_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          angle_d = angle_arr[pick_idx];
          id_d    = pick_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done strobe in the timeout cycle still counts as success.
        if (core_done) begin
          sine_d   = core_sine;
          cosine_d = core_cosine;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          sine_d   = '0;
          cosine_d = '0;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latch registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      timer_q  <= '0;
      angle_q  <= '0;
      id_q     <= '0;
      sine_q   <= '0;
      cosine_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      timer_q  <= timer_d;
      angle_q  <= angle_d;
      id_q     <= id_d;
      sine_q   <= sine_d;
      cosine_q <= cosine_d;
      err_q    <= err_d;
    end
  end

endmodule
